// File: rtl/alu_seq_pkg.sv
// Shared opcode bit indices and sequencer state type for the ALU sequencer,
// the ALU datapath and the control unit.
`timescale 1ns/1ps
package alu_seq_pkg;

    localparam int OP_W = 16;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_NEG = 2;
    localparam int OP_MUL = 3;
    localparam int OP_DIV = 4;
    localparam int OP_AND = 5;
    localparam int OP_OR  = 6;
    localparam int OP_ROR = 7;
    localparam int OP_ROL = 8;
    localparam int OP_SLL = 9;
    localparam int OP_SRA = 10;
    localparam int OP_SRL = 11;
    localparam int OP_NOT = 12;
    localparam int OP_INC = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

    // Bits 14/15 are unassigned, so they make an opcode illegal even when one-hot.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return $onehot(op) && !op[15] && !op[14];
    endfunction

endpackage

// File: rtl/alu_seq_cnt.sv
// Loadable 8-bit down-counter with zero flag; holds at zero rather than wrapping.
`timescale 1ns/1ps
module alu_seq_cnt (
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != 8'd0)) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign zero = (cnt == 8'd0);

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU opcode sequencer with valid/ready request and response sides.
// Optional illegal-opcode rejection when ALU_SEQ_ONEHOT_CHECK_EN is defined.
//
//   state   | meaning
//   IDLE    | ready for a request, ALU opcode idle
//   EXEC    | opcode driven to the ALU while the cycle counter runs down
//   RESP    | HI/LO result held until the consumer accepts
`timescale 1ns/1ps
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DIV_CYCLES = 34,
    parameter int MUL_CYCLES = 1
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [31:0]     req_x,
    input  logic [31:0]     req_y,
    output logic [31:0]     alu_x,
    output logic [31:0]     alu_y,
    output logic [OP_W-1:0] alu_op,
    input  logic [63:0]     alu_z,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_hi,
    output logic [31:0]     rsp_lo,
    output logic            rsp_err
);

    seq_state_t      state, next_state;
    logic [OP_W-1:0] op_q;
    logic            accept;
    logic            capture;
    logic            req_bad;
    logic            cnt_zero;
    logic [7:0]      load_val;

`ifdef ALU_SEQ_ONEHOT_CHECK_EN
    assign req_bad = !op_is_legal(req_op);
`else
    assign req_bad = 1'b0;
`endif

    // DIV wins over MUL when both bits are set so the divider never gets a short enable.
    always_comb begin
        load_val = 8'd0;
        if (req_op[OP_DIV]) begin
            load_val = 8'(DIV_CYCLES - 1);
        end else if (req_op[OP_MUL]) begin
            load_val = 8'(MUL_CYCLES - 1);
        end
    end

    alu_seq_cnt u_cnt (
        .clk      (clk),
        .clear    (clear),
        .load     (accept),
        .load_val (load_val),
        .dec      (state == ST_EXEC),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        alu_op     = '0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = req_bad ? ST_RESP : ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op = op_q;
                if (cnt_zero) begin
                    capture    = 1'b1;
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            op_q  <= '0;
            alu_x <= 32'd0;
            alu_y <= 32'd0;
        end else if (accept) begin
            op_q  <= req_op;
            alu_x <= req_x;
            alu_y <= req_y;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            rsp_hi <= 32'd0;
            rsp_lo <= 32'd0;
        end else if (accept && req_bad) begin
            rsp_hi <= 32'd0;
            rsp_lo <= 32'd0;
        end else if (capture) begin
            rsp_hi <= alu_z[63:32];
            rsp_lo <= alu_z[31:0];
        end
    end

`ifdef ALU_SEQ_ONEHOT_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= req_bad;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus random ops against a
// behavioural ALU stub whose result is only valid after the required enable cycles.
`timescale 1ns/1ps
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int DIVC = 34;
    localparam int MULC = 3;

    logic            clk = 1'b0;
    logic            clear;
    logic            req_valid;
    logic            req_ready;
    logic [OP_W-1:0] req_op;
    logic [31:0]     req_x, req_y;
    logic [31:0]     alu_x, alu_y;
    logic [OP_W-1:0] alu_op;
    logic [63:0]     alu_z;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_hi, rsp_lo;
    logic            rsp_err;

    int vectors     = 0;
    int miscompares = 0;
    int en_cnt      = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.DIV_CYCLES(DIVC), .MUL_CYCLES(MULC)) dut (
        .clk       (clk),
        .clear     (clear),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_x     (req_x),
        .req_y     (req_y),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_op    (alu_op),
        .alu_z     (alu_z),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hi    (rsp_hi),
        .rsp_lo    (rsp_lo),
        .rsp_err   (rsp_err)
    );

    // Behavioural ALU: LO = quotient / low product, HI = remainder / high product.
    function automatic logic [63:0] alu_ref(input logic [15:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        int          s;
        s = int'(y[4:0]);
        r = 32'd0;
        if (op[4]) return (y == 32'd0) ? 64'd0 : {x % y, x / y};
        if (op[3]) return {32'd0, x} * {32'd0, y};
        if      (op[0])  r = x + y;
        else if (op[1])  r = x - y;
        else if (op[2])  r = 32'd0 - x;
        else if (op[5])  r = x & y;
        else if (op[6])  r = x | y;
        else if (op[7])  r = (s == 0) ? x : ((x >> s) | (x << (32 - s)));
        else if (op[8])  r = (s == 0) ? x : ((x << s) | (x >> (32 - s)));
        else if (op[9])  r = x << s;
        else if (op[10]) r = $signed(x) >>> s;
        else if (op[11]) r = x >> s;
        else if (op[12]) r = ~x;
        else if (op[13]) r = x + 32'd1;
        return {32'd0, r};
    endfunction

    // Counts consecutive cycles the opcode has been held; result is garbage until the last one.
    always @(posedge clk) begin
        if (alu_op == '0) en_cnt <= 0;
        else              en_cnt <= en_cnt + 1;
    end

    always_comb begin
        int need;
        need  = alu_op[4] ? DIVC : (alu_op[3] ? MULC : 1);
        alu_z = 64'hDEAD_BEEF_DEAD_BEEF;
        if (alu_op != '0 && en_cnt == need - 1) alu_z = alu_ref(alu_op, alu_x, alu_y);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after retirement.
    task automatic run_op(input logic [15:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int hold, input bit pest);
        int          n, ncyc, exp_lat;
        logic [63:0] exp_rsp;
        logic        exp_err;
        ncyc    = op[4] ? DIVC : (op[3] ? MULC : 1);
        exp_err = 1'b0;
        exp_rsp = alu_ref(op, x, y);
`ifdef ALU_SEQ_ONEHOT_CHECK_EN
        if (!($onehot(op) && op[15:14] == 2'b00)) begin
            ncyc    = 0;
            exp_err = 1'b1;
            exp_rsp = 64'd0;
        end
`endif
        exp_lat = ncyc + 1;
        chk("idle_ready", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
        @(negedge clk);
        req_valid = pest; req_op = 16'h0001; req_x = ~x; req_y = ~y;
        n = 1;
        while (!rsp_valid && n < 400) begin
            chk("exec_alu_op", alu_op, (n <= ncyc) ? op : 16'h0000);
            chk("exec_req_ready", req_ready, 0);
            chk("exec_operands", {alu_x, alu_y}, {x, y});
            rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        chk("latency", n, exp_lat);
        rsp_ready = 1'b0;
        for (int i = 0; i <= hold; i++) begin
            chk("rsp_data", {rsp_hi, rsp_lo}, exp_rsp);
            chk("rsp_err", rsp_err, exp_err);
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_req_ready", req_ready, 0);
            chk("rsp_alu_op", alu_op, 0);
            chk("rsp_operands", {alu_x, alu_y}, {x, y});
            if (i == hold) rsp_ready = 1'b1;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("retired_valid", rsp_valid, 0);
        chk("retired_req_ready", req_ready, 1);
        chk("retired_operands", {alu_x, alu_y}, {x, y});
        req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] op;
        logic [31:0] x, y;
        clear = 1'b1; req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0; rsp_ready = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_alu_op", alu_op, 0);
        chk("reset_operands", {alu_x, alu_y}, 64'd0);
        chk("reset_rsp", {rsp_hi, rsp_lo}, 64'd0);
        chk("reset_rsp_err", rsp_err, 0);
        clear = 1'b0;
        @(negedge clk);

        run_op(16'h0001, 32'd10, 32'd5, 0, 1'b0);
        chk("add_lo", rsp_lo, 32'd15);
        run_op(16'h0010, 32'd20, 32'd5, 0, 1'b0);
        chk("div_lo", rsp_lo, 32'd4);
        run_op(16'h0008, 32'd4, 32'd3, 5, 1'b1);
        chk("mul_lo", rsp_lo, 32'd12);
        run_op(16'h1000, 32'hAAAA_AAAA, 32'd0, 0, 1'b1);
        chk("not_lo", rsp_lo, 32'h5555_5555);
        run_op(16'h0002, 32'd15, 32'd5, 1, 1'b0);
        chk("sub_lo", rsp_lo, 32'd10);

        // clear ten cycles into a divide
        req_valid = 1'b1; req_op = 16'h0010; req_x = 32'd20; req_y = 32'd5;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("clr_pre_alu_op", alu_op, 16'h0010);
        #2 clear = 1'b1;
        #1;
        chk("clr_alu_op", alu_op, 0);
        chk("clr_rsp_valid", rsp_valid, 0);
        chk("clr_req_ready", req_ready, 1);
        chk("clr_operands", {alu_x, alu_y}, 64'd0);
        chk("clr_rsp", {rsp_hi, rsp_lo, 31'd0, rsp_err}, 96'd0);
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        chk("clr_no_rsp", rsp_valid, 0);
        run_op(16'h0001, 32'd1, 32'd1, 0, 1'b0);
        chk("post_clr_add", rsp_lo, 32'd2);

        run_op(16'h0030, 32'd20, 32'd5, 1, 1'b0);
        run_op(16'h4000, 32'd7, 32'd9, 0, 1'b0);

        repeat (40) begin
            op = 16'h0001 << $urandom_range(0, 13);
            x  = $urandom;
            y  = op[4] ? 32'($urandom_range(1, 5000)) : $urandom;
            run_op(op, x, y, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
